mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_lat_cnt.sv | 27 ++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;
  localparam logic [31:0] EOF_ADDR   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_lat_cnt.sv
// ACCESS-phase latency counter: loads MEM_LAT-1, counts down, flags the last cycle.
module mem_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(MEM_LAT - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for instruction fetch and data load/store.
// Optional: define ARB_ROUND_ROBIN_EN for alternating grants on contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              halted
);

  state_t            r_state;
  state_t            w_state_nxt;
  gnt_t              r_gnt;
  gnt_t              w_gnt_sel;
  logic              w_grant;
  logic              w_finish;
  logic              w_last;
  logic              w_if_eof;
  logic              r_we;
  logic              r_eof;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_halted;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  mem_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_grant),
    .o_last_c (w_last)
  );

  assign w_if_eof = (if_addr == ADDR_W'(EOF_ADDR));

`ifdef ARB_ROUND_ROBIN_EN
  gnt_t r_last_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= GNT_IF;
    end else if (w_grant) begin
      r_last_gnt <= w_gnt_sel;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grant and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req && d_req) begin
      w_gnt_sel = (r_last_gnt == GNT_IF) ? GNT_D : GNT_IF;
    end else begin
      w_gnt_sel = d_req ? GNT_D : GNT_IF;
    end
`else
    w_gnt_sel = d_req ? GNT_D : GNT_IF;
`endif
    case (r_state)
      IDLE: begin
        if (!r_halted && (if_req || d_req)) begin
          w_grant     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Granted request latch, strobes, read capture and acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= GNT_IF;
      r_we        <= 1'b0;
      r_eof       <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_halted    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_grant) begin
        r_gnt <= w_gnt_sel;
        if (w_gnt_sel == GNT_D) begin
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
          r_we        <= d_we;
          r_eof       <= 1'b0;
          r_mem_read  <= ~d_we;
          r_mem_write <= d_we;
        end else begin
          r_mem_addr  <= if_addr;
          r_we        <= 1'b0;
          r_eof       <= w_if_eof;
          r_mem_read  <= ~w_if_eof;
          r_mem_write <= 1'b0;
        end
      end
      if (w_finish) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (r_gnt == GNT_D) begin
          r_d_ack <= 1'b1;
          if (!r_we) begin
            r_d_rdata <= mem_rdata;
          end
        end else begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= r_eof ? '0 : mem_rdata;
          if (r_eof) begin
            r_halted <= 1'b1;
          end
        end
      end
    end
  end

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign halted    = r_halted;
  assign stall     = (if_req | d_req) & ~(r_if_ack | r_d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven scoreboard bench for mem_arbiter (MEM_LAT=2); follows ARB_ROUND_ROBIN_EN if defined.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned NVEC    = 10;

  typedef struct {
    logic        use_i;
    logic        use_d;
    logic        d_we;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        we;
    logic        eof;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        halted;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        mon_en = 1'b0;
  logic        last_d = 1'b0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  logic        exp_halted = 1'b0;
  sb_t         sb[$];
  sb_t         mon_e;
  vec_t        vecs[NVEC];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata),
    .stall(stall), .halted(halted)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: strobes, addresses, ack ordering/timing, read data.
  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      check("ack_excl", 32'(if_ack & d_ack), 32'd0);
      check("stall", 32'(stall), 32'((if_req | d_req) & ~(if_ack | d_ack)));
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read || mem_write) begin
        if (sb.size() == 0) begin
          check("strobe_unexpected", 32'({mem_read, mem_write}), 32'd0);
        end else begin
          check("mem_addr", mem_addr, sb[0].addr);
          if (mem_write) check("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end
      if (if_ack || d_ack) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", 32'({if_ack, d_ack}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("ack_port", 32'({if_ack, d_ack}), mon_e.is_d ? 32'd1 : 32'd2);
          check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
          check("rd_strobes", 32'(rd_cnt), (!mon_e.we && !mon_e.eof) ? 32'(MEM_LAT) : 32'd0);
          check("wr_strobes", 32'(wr_cnt), mon_e.we ? 32'(MEM_LAT) : 32'd0);
          if (mon_e.is_d) begin
            if (!mon_e.we) exp_d_rdata = mon_e.rdata;
          end else begin
            exp_if_rdata = mon_e.rdata;
          end
          if (mon_e.eof) exp_halted = 1'b1;
          check("if_rdata", if_rdata, exp_if_rdata);
          check("d_rdata", d_rdata, exp_d_rdata);
          check("halted", 32'(halted), 32'(exp_halted));
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    sb_t  e_i;
    sb_t  e_d;
    int   t;
    logic d_first;
    logic ai;
    logic ad;
    @(posedge clk);
    #1;
    t       = cyc;
    if_req  = v.use_i;
    if_addr = v.i_addr;
    d_req   = v.use_d;
    d_we    = v.d_we;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    e_i.is_d  = 1'b0;
    e_i.we    = 1'b0;
    e_i.eof   = (v.i_addr == 32'hFFFF_FFFF);
    e_i.addr  = v.i_addr;
    e_i.wdata = '0;
    e_i.rdata = e_i.eof ? 32'd0 : mem_f(v.i_addr);
    e_d.is_d  = 1'b1;
    e_d.we    = v.d_we;
    e_d.eof   = 1'b0;
    e_d.addr  = v.d_addr;
    e_d.wdata = v.d_wdata;
    e_d.rdata = mem_f(v.d_addr);
    if (v.use_i && v.use_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      d_first = ~last_d;
`else
      d_first = 1'b1;
`endif
      e_i.ack_cyc = d_first ? t + 2 * MEM_LAT + 3 : t + MEM_LAT + 1;
      e_d.ack_cyc = d_first ? t + MEM_LAT + 1 : t + 2 * MEM_LAT + 3;
      if (d_first) begin
        sb.push_back(e_d);
        sb.push_back(e_i);
      end else begin
        sb.push_back(e_i);
        sb.push_back(e_d);
      end
      last_d = ~d_first;
    end else if (v.use_d) begin
      e_d.ack_cyc = t + MEM_LAT + 1;
      sb.push_back(e_d);
      last_d = 1'b1;
    end else if (v.use_i) begin
      e_i.ack_cyc = t + MEM_LAT + 1;
      sb.push_back(e_i);
      last_d = 1'b0;
    end
    for (int k = 0; k < 4 * (MEM_LAT + 2) + 10 && (if_req || d_req); k++) begin
      @(negedge clk);
      ai = if_ack;
      ad = d_ack;
      @(posedge clk);
      #1;
      if (ai) if_req = 1'b0;
      if (ad) d_req = 1'b0;
    end
    if (if_req || d_req) begin
      check("ack_timeout", 32'({if_req, d_req}), 32'd0);
      if_req = 1'b0;
      d_req  = 1'b0;
      sb.delete();
    end
  endtask

  task automatic reset_model();
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    exp_halted   = 1'b0;
    last_d       = 1'b0;
    rd_cnt       = 0;
    wr_cnt       = 0;
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_0010, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_0010, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_0010, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_0010, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0020, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0040, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0010, 32'h0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h0000_3008, 32'h0000_0024, 32'h1234_5678};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h0000_3010, 32'h0, 32'h0};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset_model();
    mon_en = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) run_vec(vecs[i]);

    // Reset during the first ACCESS cycle of a load abandons it.
    mon_en = 1'b0;
    @(posedge clk);
    #1 d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    check("rstacc_read_active", 32'(mem_read), 32'd1);
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstacc_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rstacc_mem_addr", mem_addr, 32'd0);
    check("rstacc_d_rdata", d_rdata, 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("rstacc_no_ack", 32'(d_ack), 32'd0);
      @(negedge clk);
    end
    reset_model();
    mon_en = 1'b1;
    run_vec(vecs[7]);
    run_vec(vecs[1]);

    // End-of-program fetch halts; further fetches stay blocked until reset.
    run_vec('{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0});
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h0000_3000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("halt_no_ack", 32'(if_ack), 32'd0);
      check("halt_no_read", 32'(mem_read), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
    end
    mon_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; if_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("halt_cleared", 32'(halted), 32'd0);
    check("halt_if_rdata", if_rdata, 32'd0);
    reset_model();
    mon_en = 1'b1;
    run_vec(vecs[0]);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
